// File: rtl/rca_seq_adder_pkg.sv
// Shared definitions for the sequential ripple-carry adder: FSM states,
// slice width, and counter sizing.
package rca_seq_adder_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   localparam int SLICE_W = 4;

   // The counter must be at least 1 bit wide, even when there is only one slice.
   function automatic int cnt_width(input int k);
      return (k > 1) ? $clog2(k) : 1;
   endfunction

endpackage

// File: rtl/rca_seq_adder_rca_4b.sv
// Combinational 4-bit ripple-carry slice (rca_4b), the datapath shared by
// every cycle of the sequential adder.
module rca_4b
   import rca_seq_adder_pkg::*;
(
   input  logic [SLICE_W-1:0] a_i,
   input  logic [SLICE_W-1:0] b_i,
   input  logic               c_i,
   output logic [SLICE_W-1:0] s_o,
   output logic               c_o
);

   logic [SLICE_W:0] c_s;

   always_comb begin
      c_s    = '0;
      s_o    = '0;
      c_s[0] = c_i;
      for (int i = 0; i < SLICE_W; i++) begin
         s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
         c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign c_o = c_s[SLICE_W];

endmodule

// File: rtl/rca_seq_adder.sv
// Multi-cycle N-bit adder: one 4-bit slice per cycle, LSB slice first.
// Optional signed-overflow output is enabled by defining RCA_SEQ_OFL_EN.
module rca_seq_adder
   import rca_seq_adder_pkg::*;
#(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic         C_in,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] S,
`ifdef RCA_SEQ_OFL_EN
   output logic         Ofl,
`endif
   output logic         C_out
);

   localparam int K  = N / SLICE_W;
   localparam int CW = cnt_width(K);

   state_e               state_q;
   logic [CW-1:0]        cnt_q;
   logic [N-1:0]         a_q, b_q, s_q;
   logic                 cy_q, cout_q, busy_q, done_q;
   logic [SLICE_W-1:0]   slice_s;
   logic                 slice_c;
   logic [N-1:0]         s_d;
`ifdef RCA_SEQ_OFL_EN
   logic                 a_sgn_q, b_sgn_q, ofl_q;
`endif

   rca_4b u_slice (
      .a_i (a_q[SLICE_W-1:0]),
      .b_i (b_q[SLICE_W-1:0]),
      .c_i (cy_q),
      .s_o (slice_s),
      .c_o (slice_c)
   );

   // The newest slice enters at the MSB end, so after K cycles the LSB slice lands at bit 0.
   assign s_d = N'({slice_s, s_q} >> SLICE_W);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cy_q    <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef RCA_SEQ_OFL_EN
         a_sgn_q <= 1'b0;
         b_sgn_q <= 1'b0;
         ofl_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= A;
                  b_q     <= B;
                  cy_q    <= C_in;
                  cnt_q   <= '0;
                  s_q     <= '0;
                  cout_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
`ifdef RCA_SEQ_OFL_EN
                  a_sgn_q <= A[N-1];
                  b_sgn_q <= B[N-1];
                  ofl_q   <= 1'b0;
`endif
               end else begin
                  state_q <= IDLE;
               end
            end
            RUN: begin
               a_q   <= a_q >> SLICE_W;
               b_q   <= b_q >> SLICE_W;
               s_q   <= s_d;
               cy_q  <= slice_c;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == CW'(K - 1)) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cout_q  <= slice_c;
`ifdef RCA_SEQ_OFL_EN
                  ofl_q   <= (a_sgn_q == b_sgn_q) && (slice_s[SLICE_W-1] != a_sgn_q);
`endif
               end else begin
                  state_q <= RUN;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy  = busy_q;
   assign done  = done_q;
   assign S     = s_q;
   assign C_out = cout_q;
`ifdef RCA_SEQ_OFL_EN
   assign Ofl   = ofl_q;
`endif

endmodule

// File: tb/tb_rca_seq_adder.sv
// Self-checking bench for rca_seq_adder (N=16): directed cases plus random adds
// against an arithmetic reference model. Ofl is checked when RCA_SEQ_OFL_EN is defined.
module tb_rca_seq_adder;

   localparam int N = 16;
   localparam int K = N / 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [N-1:0] A = '0, B = '0;
   logic         C_in = 1'b0;
   logic         busy, done, C_out;
   logic [N-1:0] S;
`ifdef RCA_SEQ_OFL_EN
   logic         Ofl;
`endif

   int n_checks = 0;
   int n_errs   = 0;

   rca_seq_adder #(.N(N)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .C_in  (C_in),
      .busy  (busy),
      .done  (done),
      .S     (S),
`ifdef RCA_SEQ_OFL_EN
      .Ofl   (Ofl),
`endif
      .C_out (C_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain unsigned and signed arithmetic.
   task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic c,
                        output logic [N-1:0] s, output logic co, output logic ov);
      int unsigned sum;
      int          ssum;
      sum  = int'(a) + int'(b) + int'(c);
      s    = N'(sum);
      co   = (sum >= (1 << N));
      ssum = int'($signed(a)) + int'($signed(b)) + int'(c);
      ov   = (ssum > 32767) || (ssum < -32768);
   endtask

   // Called at a negedge: present operands, then drop start after the accepting edge.
   task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      A = a; B = b; C_in = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at the negedge after E0; returns edges from E0 until done is seen.
   task automatic wait_done(output int lat, output int busy_bad);
      lat = 0;
      busy_bad = 0;
      while (!done && lat < 40) begin
         if (!busy) busy_bad++;
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic check_result(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic c, input int lat, input int busy_bad);
      logic [N-1:0] es;
      logic eco, eov;
      model(a, b, c, es, eco, eov);
      check({tag, ".lat"},  32'(lat), 32'(K));
      check({tag, ".busy"}, 32'(busy_bad), 32'd0);
      check({tag, ".S"},    32'(S), 32'(es));
      check({tag, ".Cout"}, 32'(C_out), 32'(eco));
`ifdef RCA_SEQ_OFL_EN
      check({tag, ".Ofl"},  32'(Ofl), 32'(eov));
`endif
   endtask

   task automatic full_add(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic c);
      int lat, bb;
      launch(a, b, c);
      wait_done(lat, bb);
      check_result(tag, a, b, c, lat, bb);
   endtask

   initial begin
      int lat, bb, pulses;
      logic [N-1:0] ra, rb, hold_s;
      logic rc, hold_c;

      #2;
      check("rst.busy", 32'(busy), 32'd0);
      check("rst.done", 32'(done), 32'd0);
      check("rst.S",    32'(S), 32'd0);
      check("rst.Cout", 32'(C_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // 1: full carry ripple
      full_add("t1", 16'hFFFF, 16'h0001, 1'b0);
      @(negedge clk);
      check("t1.done_once", 32'(done), 32'd0);

      // 2: carry-in used, then results hold while idle
      full_add("t2", 16'h1234, 16'h4321, 1'b1);
      hold_s = S; hold_c = C_out;
      for (int i = 0; i < 3; i++) @(negedge clk);
      check("t2.holdS",    32'(S), 32'h5556);
      check("t2.holdCout", 32'(C_out), 32'd0);
      check("t2.done0",    32'(done), 32'd0);

      // 3: start while busy is ignored
      launch(16'h00FF, 16'h0001, 1'b0);
      @(negedge clk);
      A = 16'hAAAA; B = 16'h5555; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bb);
      lat += 2;
      check_result("t3", 16'h00FF, 16'h0001, 1'b0, lat, bb);
      check("t3.S", 32'(S), 32'h0100);

      // 4: back-to-back start during the done cycle
      launch(16'h8000, 16'h8000, 1'b0);
      check("t4.busy",   32'(busy), 32'd1);
      check("t4.done",   32'(done), 32'd0);
      check("t4.Sclr",   32'(S), 32'd0);
      check("t4.Cclr",   32'(C_out), 32'd0);
      wait_done(lat, bb);
      check_result("t4", 16'h8000, 16'h8000, 1'b0, lat, bb);
      check("t4.Cout", 32'(C_out), 32'd1);

      // 5: asynchronous reset mid-run
      @(negedge clk);
      full_add("t5pre", 16'h0F0F, 16'h0101, 1'b1);
      @(negedge clk);
      launch(16'h1111, 16'h2222, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5.busy", 32'(busy), 32'd0);
      check("t5.done", 32'(done), 32'd0);
      check("t5.S",    32'(S), 32'd0);
      check("t5.Cout", 32'(C_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      check("t5.nodone", 32'(pulses), 32'd0);

      // 6: overflow boundaries
      full_add("t6a", 16'h7FFF, 16'h0001, 1'b0);
      check("t6a.S", 32'(S), 32'h8000);
      @(negedge clk);
      full_add("t6b", 16'hFFFF, 16'h0001, 1'b0);

      // Random adds, alternating idle gaps and back-to-back starts
      for (int i = 0; i < 40; i++) begin
         ra = N'($urandom);
         rb = N'($urandom);
         rc = 1'($urandom);
         if (i % 3 == 0) @(negedge clk);
         full_add("rnd", ra, rb, rc);
      end

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
